// File: rtl/modulo_scan_mux36_1.sv
// 36:1 read-back scanner: dwells DWELL clocks per select value, samples line 35-sel,
// streams each sample serially and publishes the assembled 36-bit frame with a one-cycle pulse.
module modulo_scan_mux36_1 #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [35:0] lines_in,
  output logic [5:0]  sel,
  output logic        serial_out,
  output logic        bit_valid,
  output logic [35:0] frame,
  output logic        frame_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [5:0]  sel_nx;
  logic [5:0]  idx;
  logic [35:0] assembly, assembly_nx;
  logic [35:0] frame_nx;
  logic        serial_nx, bit_valid_nx, frame_valid_nx, busy_nx;

  // select k addresses line 35-k, matching the demux side of the fabric
  assign idx = 6'd35 - sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= '0;
      assembly    <= '0;
      serial_out  <= 1'b0;
      bit_valid   <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sel         <= sel_nx;
      assembly    <= assembly_nx;
      serial_out  <= serial_nx;
      bit_valid   <= bit_valid_nx;
      frame       <= frame_nx;
      frame_valid <= frame_valid_nx;
      busy        <= busy_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    sel_nx         = sel;
    assembly_nx    = assembly;
    serial_nx      = serial_out;
    bit_valid_nx   = 1'b0;
    frame_nx       = frame;
    frame_valid_nx = 1'b0;
    case (state)
      IDLE: begin
        sel_nx = '0;
        cnt_nx = '0;
        if (start) state_nx = SCAN;
      end
      SCAN: begin
        if (cnt == LAST) begin
          assembly_nx[idx] = lines_in[idx];
          serial_nx        = lines_in[idx];
          bit_valid_nx     = 1'b1;
          cnt_nx           = '0;
          if (sel == 6'd35) state_nx = DONE;
          else              sel_nx   = sel + 6'd1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DONE: begin
        frame_nx       = assembly;
        frame_valid_nx = 1'b1;
        sel_nx         = '0;
        cnt_nx         = '0;
        state_nx       = continuous ? SCAN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_modulo_scan_mux36_1.sv
// Directed bench for modulo_scan_mux36_1: one DWELL=4 instance and one DWELL=1 instance.
module tb_modulo_scan_mux36_1;

  logic        clk = 1'b0;
  logic        reset, start, start1, continuous;
  logic [35:0] lines_in;

  logic [5:0]  sel4, sel1;
  logic        so4, so1, bv4, bv1, fv4, fv1, busy4, busy1;
  logic [35:0] frame4, frame1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  modulo_scan_mux36_1 #(.DWELL(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .lines_in(lines_in),
    .sel(sel4), .serial_out(so4), .bit_valid(bv4), .frame(frame4),
    .frame_valid(fv4), .busy(busy4)
  );

  modulo_scan_mux36_1 #(.DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .continuous(continuous), .lines_in(lines_in),
    .sel(sel1), .serial_out(so1), .bit_valid(bv1), .frame(frame1),
    .frame_valid(fv1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame, edge n counted from the start edge (or from the previous frame's
  // DONE edge when do_start=0). inj>=0 pulses start on edge inj of the DWELL=4 unit.
  task automatic run_scan(input bit which, input bit do_start, input int inj,
                          output int fv_edge, output int nbits,
                          output logic [35:0] seq, output int sel_err);
    int d;
    int exp_sel;
    logic [5:0] o_sel;
    d = which ? 1 : 4;
    fv_edge = -1;
    nbits   = 0;
    seq     = '0;
    sel_err = 0;
    if (do_start) begin
      if (which) start1 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start1 = 1'b0;
    end
    for (int n = 1; n <= 36*d + 10; n++) begin
      start = (!which && n == inj);
      @(posedge clk); #1;
      start = 1'b0;
      o_sel   = which ? sel1 : sel4;
      exp_sel = (n < 36*d) ? n / d : 35;
      if (n <= 36*d && int'(o_sel) != exp_sel) sel_err++;
      if (which ? bv1 : bv4) begin
        nbits++;
        seq = {seq[34:0], (which ? so1 : so4)};
      end
      if (which ? fv1 : fv4) begin
        fv_edge = n;
        break;
      end
    end
  endtask

  int          fv_edge, nbits, sel_err;
  logic [35:0] seq;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start1     = 1'b0;
    continuous = 1'b0;
    lines_in   = '0;
    #1;
    chk("reset_sel",    64'(sel4), 64'd0);
    chk("reset_serial", 64'(so4), 64'd0);
    chk("reset_bv",     64'(bv4), 64'd0);
    chk("reset_frame",  64'(frame4), 64'd0);
    chk("reset_fv",     64'(fv4), 64'd0);
    chk("reset_busy",   64'(busy4), 64'd0);
    chk("reset_frame1", 64'(frame1), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // basic scan, DWELL=4
    lines_in = 36'h8_0000_0001;
    run_scan(1'b0, 1'b1, -1, fv_edge, nbits, seq, sel_err);
    chk("basic_fv_edge", 64'(fv_edge), 64'd145);
    chk("basic_nbits",   64'(nbits), 64'd36);
    chk("basic_serial",  64'(seq), 64'h8_0000_0001);
    chk("basic_frame",   64'(frame4), 64'h8_0000_0001);
    chk("basic_sel_seq", 64'(sel_err), 64'd0);
    chk("basic_busy",    64'(busy4), 64'd0);
    chk("basic_sel_idle",64'(sel4), 64'd0);
    lines_in = 36'h0_1234_5678;
    @(posedge clk); #1;
    chk("basic_fv_pulse", 64'(fv4), 64'd0);
    chk("basic_frame_hold", 64'(frame4), 64'h8_0000_0001);

    // start pulsed at sel=10 must not disturb the scan
    lines_in = 36'h1_2345_6789;
    run_scan(1'b0, 1'b1, 41, fv_edge, nbits, seq, sel_err);
    chk("busy_start_fv_edge", 64'(fv_edge), 64'd145);
    chk("busy_start_nbits",   64'(nbits), 64'd36);
    chk("busy_start_frame",   64'(frame4), 64'h1_2345_6789);
    chk("busy_start_sel_seq", 64'(sel_err), 64'd0);

    // continuous mode: back-to-back frames
    continuous = 1'b1;
    lines_in   = 36'hA_AAAA_AAAA;
    run_scan(1'b0, 1'b1, -1, fv_edge, nbits, seq, sel_err);
    chk("cont_fv_edge0", 64'(fv_edge), 64'd145);
    chk("cont_serial0",  64'(seq), 64'hA_AAAA_AAAA);
    chk("cont_busy0",    64'(busy4), 64'd1);
    chk("cont_sel0",     64'(sel4), 64'd0);
    continuous = 1'b0;
    run_scan(1'b0, 1'b0, -1, fv_edge, nbits, seq, sel_err);
    chk("cont_fv_gap",   64'(fv_edge), 64'd145);
    chk("cont_nbits1",   64'(nbits), 64'd36);
    chk("cont_frame1",   64'(frame4), 64'hA_AAAA_AAAA);
    chk("cont_sel_seq1", 64'(sel_err), 64'd0);
    chk("cont_busy_end", 64'(busy4), 64'd0);

    // asynchronous reset mid-scan at sel=20
    lines_in = 36'h5_5555_5555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_sel_before", 64'(sel4), 64'd20);
    #2 reset = 1'b1;
    #1;
    chk("abort_sel",   64'(sel4), 64'd0);
    chk("abort_busy",  64'(busy4), 64'd0);
    chk("abort_frame", 64'(frame4), 64'd0);
    chk("abort_serial",64'(so4), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    lines_in = 36'hF_0000_000F;
    run_scan(1'b0, 1'b1, -1, fv_edge, nbits, seq, sel_err);
    chk("abort_fv_edge", 64'(fv_edge), 64'd145);
    chk("abort_frame_new", 64'(frame4), 64'hF_0000_000F);
    chk("abort_nbits", 64'(nbits), 64'd36);

    // DWELL=1 boundary
    lines_in = 36'hF_FFFF_FFFF;
    run_scan(1'b1, 1'b1, -1, fv_edge, nbits, seq, sel_err);
    chk("d1_fv_edge", 64'(fv_edge), 64'd37);
    chk("d1_nbits",   64'(nbits), 64'd36);
    chk("d1_frame",   64'(frame1), 64'hF_FFFF_FFFF);
    chk("d1_sel_seq", 64'(sel_err), 64'd0);
    chk("d1_busy",    64'(busy1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/modulo_scan_mux36_1.md
Name: modulo_scan_mux36_1

Overview:
- Sequential 36:1 read-back scanner. It is the collecting end of the 36-line select fabric driven by modulo_demux1_36.
- Steps a 6-bit select through lines 0..35 and dwells DWELL clocks on each line.
- At the end of each dwell it samples the selected line. It emits each sample serially and assembles all 36 samples into a frame word with a one-cycle valid pulse.
- Line mapping matches the demux convention: select value k addresses line index 35-k.

Parameters:
DWELL, 4, clocks spent on each select value before sampling; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  begin a scan when IDLE; ignored while busy.
continuous  input  1  sampled in DONE; 1 = restart immediately, 0 = return to IDLE.
lines_in  input  36  parallel line inputs; bit 35-k is read while sel=k.
sel  output  6  current select value, 0..35; feeds the demux select.
serial_out  output  1  most recent sampled bit.
bit_valid  output  1  one-cycle pulse: serial_out holds a new sample.
frame  output  36  last completed frame; bit 35-k holds the sample taken at sel=k.
frame_valid  output  1  one-cycle pulse: frame just updated.
busy  output  1  high in SCAN and DONE.

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state=IDLE; sel=0; dwell counter=0.
  - serial_out=0, bit_valid=0, frame=0, frame_valid=0, busy=0; internal assembly register cleared.
  - A partial frame is discarded and never published.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, busy=0.
  - start=1 at edge E0 → SCAN, sel=0, cnt=0.
- SCAN:
  - cnt counts 0..DWELL-1 while sel is held stable.
  - On the edge where cnt==DWELL-1:
    - assembly[35-sel] <= lines_in[35-sel]; serial_out <= the same bit.
    - bit_valid=1 for the following cycle only.
    - If sel<35: sel<=sel+1, cnt<=0. If sel==35: → DONE, sel held at 35.
  - Line k is therefore sampled at edge E(DWELL*(k+1)).
  - DWELL=1 gives one line per clock.
- DONE (exactly one cycle; entered at E(36*DWELL)):
  - At E(36*DWELL+1): frame <= assembly, and frame_valid=1 for the following cycle.
  - continuous=1 → SCAN with sel=0, cnt=0 at that same edge; the next frame's line-0 sample lands at E(36*DWELL+1+DWELL).
  - continuous=0 → IDLE, sel=0.
- start:
  - Ignored in SCAN and DONE; no restart and no effect on the count.
  - A start held high in IDLE begins a new scan on every IDLE entry.
- sel never exceeds 35; codes 36..63 are never driven.
- lines_in is sampled only on sample edges; changes between those edges have no effect.
- Frame update: frame changes only on frame_valid edges and holds between pulses.
- Latency from the start edge:
  - first bit_valid in cycle DWELL+1;
  - frame_valid in cycle 36*DWELL+2.
- Total bit_valid pulses per frame: exactly 36.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle → all outputs zero immediately, with no clock edge needed.
- Basic scan: DWELL=4, lines_in=36'h8_0000_0001, one start pulse →
  - sel steps 0..35, changing every 4 clocks;
  - serial bit sequence 1, then 34 zeros, then 1;
  - exactly 36 bit_valid pulses;
  - frame=36'h8_0000_0001 with frame_valid in cycle 146, then IDLE with busy=0.
- Continuous mode: continuous=1, lines_in=36'hA_AAAA_AAAA →
  - back-to-back frames, frame_valid pulses 145 clocks apart;
  - serial pattern 1,0,1,0,...;
  - sel returns to 0 with no idle gap.
- Start ignored while busy: pulse start at sel=10 → the scan is neither restarted nor disturbed; frame_valid timing is unchanged.
- Reset mid-scan: reset at sel=20, then a new start with lines_in=36'hF_0000_000F → frame equals 36'hF_0000_000F, with no residue from the aborted scan.
- DWELL=1 boundary: lines_in=36'hF_FFFF_FFFF → sel increments every clock; frame=all ones with frame_valid in cycle 38.
